// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin share of the vga_adapter pixel port; grant is combinational, pixel registered 1 cycle later.
// Optional macro PIXEL_ARB_CLEAR_EN adds a full-screen clear sequencer that owns the port after reset / on clear_start.
module pixel_write_arbiter #(
    parameter int         NUM_REQ      = 3,
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot
);
    localparam int            IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [7:0]    X_LIM     = 8'(X_MAX);
    localparam logic [6:0]    Y_LIM     = 7'(Y_MAX);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;
    logic [IW-1:0] rr_idx;
    logic          found;
    logic          arb_en;
    logic          take;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [2:0]    sel_colour;
    logic          sel_in_range;

`ifdef PIXEL_ARB_CLEAR_EN
    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] sweep_x, sweep_x_nxt;
    logic [6:0] sweep_y, sweep_y_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= CLEAR;
            sweep_x <= '0;
            sweep_y <= '0;
        end else begin
            state   <= state_nxt;
            sweep_x <= sweep_x_nxt;
            sweep_y <= sweep_y_nxt;
        end
    end

    // Counters are left at (0,0) when a sweep ends, so a later clear_start starts from the origin.
    always_comb begin
        state_nxt   = state;
        sweep_x_nxt = sweep_x;
        sweep_y_nxt = sweep_y;
        case (state)
            ARB: begin
                if (clear_start) begin
                    state_nxt   = CLEAR;
                    sweep_x_nxt = '0;
                    sweep_y_nxt = '0;
                end
            end
            CLEAR: begin
                if (sweep_x == X_LIM) begin
                    sweep_x_nxt = '0;
                    if (sweep_y == Y_LIM) begin
                        sweep_y_nxt = '0;
                        state_nxt   = ARB;
                    end else begin
                        sweep_y_nxt = sweep_y + 7'd1;
                    end
                end else begin
                    sweep_x_nxt = sweep_x + 8'd1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign clear_busy = (state == CLEAR);
    // clear_start wins over any same-cycle request, which stays pending.
    assign arb_en     = (state == ARB) && !clear_start;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clear_busy         = 1'b0;
    assign arb_en             = 1'b1;
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        rr_idx = last;
        cand   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign take = resetn && arb_en && found;

    always_comb begin
        grant      = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_idx == IW'(i)) begin
                grant[i]   = take;
                sel_x      = req_x[8*i +: 8];
                sel_y      = req_y[7*i +: 7];
                sel_colour = req_colour[3*i +: 3];
            end
        end
    end

    assign sel_in_range = (sel_x <= X_LIM) && (sel_y <= Y_LIM);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last       <= LAST_INIT;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
`ifdef PIXEL_ARB_CLEAR_EN
            if (state == CLEAR) begin
                vga_x      <= sweep_x;
                vga_y      <= sweep_y;
                vga_colour <= CLEAR_COLOUR;
                vga_plot   <= 1'b1;
            end else
`endif
            if (take) begin
                last       <= rr_idx;
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
                // Off-screen pixels complete the handshake but never strobe the adapter.
                vga_plot   <= sel_in_range;
            end else begin
                vga_plot   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: a negedge monitor predicts grants and pushes expected pixels to a queue,
// then pops and compares them against vga_* one cycle later.
module tb_pixel_write_arbiter;
    localparam int         NUM_REQ      = 3;
    localparam int         X_MAX        = 159;
    localparam int         Y_MAX        = 119;
    localparam logic [2:0] CLEAR_COLOUR = 3'b000;
    localparam bit CLR_EN =
`ifdef PIXEL_ARB_CLEAR_EN
        1'b1;
`else
        1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   grant;
    logic                 clear_start;
    logic                 clear_busy;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;

    pixel_write_arbiter #(
        .NUM_REQ(NUM_REQ), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .CLEAR_COLOUR(CLEAR_COLOUR)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .grant(grant), .clear_start(clear_start),
        .clear_busy(clear_busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       plot;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t shadow   = '0;
    int   m_last   = NUM_REQ - 1;
    bit   m_clr    = CLR_EN;
    int   m_sx     = 0;
    int   m_sy     = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int lst);
        for (int n = 0; n < NUM_REQ; n++) begin
            int i = (lst + 1 + n) % NUM_REQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t               e;
            logic [NUM_REQ-1:0] eg;
            int                 w;
            // Outputs produced by the previous edge.
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                shadow = e;
            end else begin
                e      = shadow;
                e.plot = 1'b0;
            end
            check("vga_plot", 32'(vga_plot), 32'(e.plot));
            check("vga_x", 32'(vga_x), 32'(e.x));
            check("vga_y", 32'(vga_y), 32'(e.y));
            check("vga_colour", 32'(vga_colour), 32'(e.c));
            check("clear_busy", 32'(clear_busy), 32'(m_clr));
            // Predict this cycle's grant and the pixel the next edge will produce.
            eg = '0;
            if (!resetn) begin
                exp_q.delete();
                shadow = '0;
                m_last = NUM_REQ - 1;
                m_clr  = CLR_EN;
                m_sx   = 0;
                m_sy   = 0;
            end else if (m_clr) begin
                exp_q.push_back({8'(m_sx), 7'(m_sy), CLEAR_COLOUR, 1'b1});
                if (m_sx == X_MAX) begin
                    m_sx = 0;
                    if (m_sy == Y_MAX) begin
                        m_sy  = 0;
                        m_clr = 1'b0;
                    end else begin
                        m_sy++;
                    end
                end else begin
                    m_sx++;
                end
            end else if (CLR_EN && clear_start) begin
                m_clr = 1'b1;
            end else begin
                w = pick(req, m_last);
                if (w >= 0) begin
                    eg[w] = 1'b1;
                    e.x   = req_x[8*w +: 8];
                    e.y   = req_y[7*w +: 7];
                    e.c   = req_colour[3*w +: 3];
                    e.plot = (int'(e.x) <= X_MAX) && (int'(e.y) <= Y_MAX);
                    exp_q.push_back(e);
                    m_last = w;
                end
            end
            check("grant", 32'(grant), 32'(eg));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
    endtask

    initial begin
        resetn      = 1'b0;
        req         = '0;
        req_x       = '0;
        req_y       = '0;
        req_colour  = '0;
        clear_start = 1'b0;
        step(1);
        mon_en = 1'b1;
        step(2);
        resetn = 1'b1;
        if (CLR_EN) step(X_MAX * 0 + (X_MAX + 1) * (Y_MAX + 1));
        step(1);

        // Single requester straight after reset / clear.
        set_pix(2, 8'd80, 7'd60, 3'b100);
        req = 3'b100;
        step(1);
        req = '0;
        step(2);

        // All three requesting: rotation 001, 010, 100, ...
        set_pix(0, 8'd10, 7'd1, 3'b001);
        set_pix(1, 8'd20, 7'd2, 3'b010);
        set_pix(2, 8'd30, 7'd3, 3'b011);
        req = 3'b111;
        step(9);
        req = '0;
        step(1);

        // Off-screen pixel: accepted, not plotted, vga_x still updates.
        set_pix(1, 8'd200, 7'd10, 3'b111);
        req = 3'b010;
        step(1);
        req = '0;
        step(2);

        // clear_start together with a request.
        set_pix(0, 8'd5, 7'd6, 3'b101);
        req         = 3'b001;
        clear_start = 1'b1;
        step(1);
        clear_start = 1'b0;
        req         = '0;
        if (CLR_EN) begin
            step(99);
            clear_start = 1'b1;
            step(1);
            clear_start = 1'b0;
            step(4900);
        end else begin
            step(2);
        end

        // Reset with a contested request pending: requester 0 must win first.
        set_pix(0, 8'd1, 7'd1, 3'b001);
        set_pix(1, 8'd2, 7'd2, 3'b010);
        req    = 3'b011;
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        if (CLR_EN) step((X_MAX + 1) * (Y_MAX + 1));
        step(4);
        req = '0;
        step(1);

        // Random traffic including boundary and off-screen coordinates.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       set_pix(i, 8'(X_MAX), 7'(Y_MAX), 3'($urandom));
                    1:       set_pix(i, 8'(X_MAX + 1), 7'($urandom), 3'($urandom));
                    default: set_pix(i, 8'($urandom), 7'($urandom), 3'($urandom));
                endcase
            end
            req = NUM_REQ'($urandom);
            step(1);
        end
        req = '0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single VGA adapter pixel-write port (x, y, colour, plot) between several drawing requesters: snake draw/erase, food spawn, score overlay. Grants one requester per clock using round-robin, registers the winning pixel onto the adapter port, and contains an optional full-screen clear sequencer that owns the port after reset or on command. Sits between the game datapath(s) and `vga_adapter` (160x120, 3-bit colour).

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- X_MAX, 159, largest legal x coordinate
- Y_MAX, 119, largest legal y coordinate
- CLEAR_COLOUR, 3'b000, colour written by the clear sequencer

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester write request
- req_x  in  8*NUM_REQ  flattened x; requester i at [8i+7:8i]
- req_y  in  7*NUM_REQ  flattened y; requester i at [7i+6:7i]
- req_colour  in  3*NUM_REQ  flattened colour; requester i at [3i+2:3i]
- grant  out  NUM_REQ  one-hot (or zero) combinational grant
- clear_start  in  1  single-cycle pulse requesting screen clear
- clear_busy  out  1  high while the clear sequencer owns the port
- vga_x  out  8  registered x to adapter
- vga_y  out  7  registered y to adapter
- vga_colour  out  3  registered colour to adapter
- vga_plot  out  1  registered write strobe to adapter

## Operation
- States: CLEAR, ARB. Reset enters CLEAR (macro defined) or ARB (macro undefined).
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, grant=0, round-robin pointer last=NUM_REQ-1 (requester 0 highest after reset), clear_busy=1 with macro / 0 without.
- Handshake: requester raises req[i] with x/y/colour stable and holds them until the cycle grant[i]=1; transfer happens on that rising edge. Requester may drop req after grant or keep it high for a new pixel next cycle.
- ARB: grant is the first asserted req searching from index last+1 upward, wrapping modulo NUM_REQ. At most one grant bit high. last updates to the granted index only on a transfer edge; no request -> last unchanged, vga_plot=0 next cycle.
- Transfer: on the edge, vga_x/y/colour <= granted fields; vga_plot <= 1 if x<=X_MAX and y<=Y_MAX, else 0 (out-of-range pixel is accepted and silently dropped; handshake still completes).
- vga_plot is high exactly one cycle per accepted, in-range transfer; vga_x/y/colour hold their last value when vga_plot=0.
- CLEAR: grant=0. Each edge drives vga_x/y = sweep counter, vga_colour=CLEAR_COLOUR, vga_plot=1; x increments 0..X_MAX, on wrap x=0 and y increments; after (X_MAX,Y_MAX) is emitted, state -> ARB and clear_busy falls on that same edge.
- clear_start in ARB: enters CLEAR on next edge, sweep from (0,0); grant forced 0 in the clear_start cycle (clear wins over simultaneous req; that req is not consumed). clear_start during CLEAR is ignored (no restart).
- Reset mid-clear or mid-arbitration: all state reinitialised; with macro the sweep restarts from (0,0).

## Timing
- Grant: combinational, same cycle as req (0 cycles). Pixel on adapter port: 1 cycle after acceptance edge (registered).
- Throughput: 1 pixel/clock sustained in both states.
- Clear duration: (X_MAX+1)*(Y_MAX+1) = 19200 edges; first edge after resetn=1 outputs (0,0), edge 19200 outputs (159,119) and drops clear_busy; first grant possible in the following cycle.
- No combinational path from req to vga_* outputs.

## Configuration
- PIXEL_ARB_CLEAR_EN defined: CLEAR state, sweep counters, auto-clear after reset, clear_start honoured, clear_busy as above.
- Undefined: CLEAR logic removed; reset enters ARB directly; clear_start ignored; clear_busy tied 0; first grant possible in the first cycle after reset.

## Test plan
- Reset then idle (macro on): clear_busy high 19200 cycles, vga_plot=1 each cycle, first (0,0) last (159,119) colour 000, then vga_plot=0.
- req=3'b111 held continuously after clear: grants cycle 001,010,100,001...; vga_x follows requester x values in that order, one per cycle.
- req[1] only with (x=200,y=10): grant[1]=1 same cycle, next cycle vga_plot=0, vga_x=200 held.
- clear_start and req[0] same cycle in ARB: grant=0, next cycle vga_plot=1 at (0,0) colour CLEAR_COLOUR; second clear_start at cycle 100 of sweep does not restart.
- resetn low for 1 cycle at sweep pixel 5000: after release sweep restarts at (0,0), pointer reset so requester 0 wins first contested grant.
- Macro off: after reset req[2] with (80,60,100) granted in first cycle, next cycle vga_plot=1 (80,60,100); clear_start produces no plot, clear_busy=0.
